prng_stream_buffer: RTL

//  Sits directly downstream of the cellular-automaton PRNG. Samples its 32-bit word every clock.

---
 rtl/prng_stream_buffer_if.sv | 20 ++
 rtl/prng_stream_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/prng_stream_buffer_if.sv
//------------------------------------------------------------------------------
// Module   : prng_stream_buffer_if
// Brief    : Valid/ready stream carrying buffered PRNG words to a consumer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface prng_stream_buffer_if #(
  parameter int N = 32
) ();
  logic [N-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

`default_nettype wire

// File: rtl/prng_stream_buffer.sv
//------------------------------------------------------------------------------
// Module   : prng_stream_buffer
// Brief    : PRNG warm-up discard, repetition-count health test, show-ahead FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module prng_stream_buffer #(
  parameter int N         = 32,
  parameter int DEPTH     = 16,
  parameter int WARMUP    = 64,
  parameter int REP_LIMIT = 4
) (
  input  wire logic                       clk_i,
  input  wire logic                       rst_ni,
  input  wire logic                       enable_i,
  input  wire logic [N-1:0]               rng_in_i,
  input  wire logic                       clear_fail_i,
  prng_stream_buffer_if.master            out_if,
  output      logic [$clog2(DEPTH):0]     fill_level_o,
  output      logic [15:0]                drop_count_o,
  output      logic                       health_fail_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WU_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_FAIL   = 2'd3
  } state_e;

  state_e             state_q;
  logic [WU_W-1:0]    warm_cnt_q;
  logic [REP_W-1:0]   rep_cnt_q;
  logic [N-1:0]       prev_q;
  logic [N-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   fill_q;
  logic [15:0]        drop_q;

  logic [REP_W-1:0]   rep_cnt_d;
  logic [CNT_W-1:0]   fill_d;
  logic               out_valid;
  logic               pop;
  logic               run_active;
  logic               fail_hit;
  logic               push_req;
  logic               full;
  logic               push_ok;
  logic               drop;

  // Sampling in RUN is gated by enable so the cycle that leaves RUN pushes nothing.
  always_comb begin
    out_valid  = (fill_q != '0) && (state_q != S_FAIL);
    pop        = out_valid && out_if.ready;
    run_active = (state_q == S_RUN) && enable_i;
    rep_cnt_d  = (rng_in_i == prev_q) ? rep_cnt_q + 1'b1 : REP_W'(1);
    fail_hit   = run_active && (rep_cnt_d == REP_W'(REP_LIMIT));
    push_req   = run_active && !fail_hit;
    full       = (fill_q == CNT_W'(DEPTH));
    push_ok    = push_req && (!full || pop);
    drop       = push_req && !push_ok;
    fill_d     = fill_q;
    if (push_ok && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!push_ok && pop) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      warm_cnt_q <= '0;
      rep_cnt_q  <= '0;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= rng_in_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      fill_q <= fill_d;
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          rep_cnt_q <= '0;
          prev_q    <= '0;
          if (enable_i) begin
            state_q    <= S_WARMUP;
            warm_cnt_q <= '0;
          end
        end
        S_WARMUP: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
          end else if (warm_cnt_q == WU_W'(WARMUP - 1)) begin
            state_q   <= S_RUN;
            prev_q    <= rng_in_i;
            rep_cnt_q <= REP_W'(1);
          end else begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!enable_i) begin
            state_q   <= S_IDLE;
            rep_cnt_q <= '0;
            prev_q    <= '0;
          end else if (fail_hit) begin
            // The flush overrides any pop or fill update scheduled above.
            state_q  <= S_FAIL;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end else begin
            prev_q    <= rng_in_i;
            rep_cnt_q <= rep_cnt_d;
          end
        end
        S_FAIL: begin
          if (clear_fail_i) begin
            state_q   <= S_IDLE;
            rep_cnt_q <= '0;
            prev_q    <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_if.data   = mem_q[rd_ptr_q];
  assign out_if.valid  = out_valid;
  assign fill_level_o  = fill_q;
  assign drop_count_o  = drop_q;
  assign health_fail_o = (state_q == S_FAIL);

endmodule

`default_nettype wire
